// File: rtl/tcp_misc_pkg.sv
// Miscellaneous TCP offload constants: scheduler-command source count and source indices.
package tcp_misc_pkg;

    localparam int NUM_SCHED_SRC     = 3;
    localparam int SCHED_SRC_RX      = 0;
    localparam int SCHED_SRC_APP     = 1;
    localparam int SCHED_SRC_TIMEOUT = 2;

endpackage

// File: rtl/tcp_pkg.sv
// Shared TCP offload types: the scheduler command carried from the requesters to the tx scheduler.
package tcp_pkg;

    localparam int FLOWID_W = 10;

    typedef enum logic [1:0] {
        SCHED_NOP  = 2'b00,
        SCHED_SET  = 2'b01,
        SCHED_CLR  = 2'b10,
        SCHED_RSVD = 2'b11
    } sched_op_e;

    // rt: retransmit timer, probe: persist/zero-window probe, ka: keepalive
    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        sched_op_e           rt;
        sched_op_e           probe;
        sched_op_e           ka;
    } sched_cmd_struct;

endpackage

// File: rtl/rr_arb_core.sv
// Round-robin grant core: pointer register, rotated priority search and one-hot grant.
module rr_arb_core #(
    parameter int NUM_SRC   = 3,
    parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_SRC-1:0]   req,
    output logic [NUM_SRC-1:0]   gnt,
    output logic [SRC_IDX_W-1:0] gnt_idx,
    output logic                 gnt_vld
);

    logic [SRC_IDX_W-1:0] rr_ptr_r;
    logic [SRC_IDX_W-1:0] cand_s;
    logic [SRC_IDX_W-1:0] pick_idx_s;
    logic                 pick_found_s;
    logic                 hit_s;

    // Search starts one past the last winner and wraps; the first requester seen wins.
    always_comb begin
        cand_s       = '0;
        hit_s        = 1'b0;
        pick_idx_s   = '0;
        pick_found_s = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand_s       = SRC_IDX_W'((int'(rr_ptr_r) + i) % NUM_SRC);
            hit_s        = !pick_found_s && req[cand_s];
            pick_idx_s   = hit_s ? cand_s : pick_idx_s;
            pick_found_s = pick_found_s | hit_s;
        end
    end

    // Grant is qualified by the enable so a blocked output never shows a ready.
    always_comb begin
        gnt_vld = en & pick_found_s;
        gnt_idx = pick_idx_s;
        if (gnt_vld) begin
            gnt = NUM_SRC'(1) << pick_idx_s;
        end else begin
            gnt = '0;
        end
    end

    // Pointer moves only when a grant actually transfers a command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= SRC_IDX_W'(NUM_SRC - 1);
        end else if (gnt_vld) begin
            rr_ptr_r <= pick_idx_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/sched_cmd_arb.sv
// Scheduler-command arbiter: round-robin selects one requester into a single registered
// output stage that feeds the tx scheduler with full throughput under continuous drain.
module sched_cmd_arb
    import tcp_pkg::*;
    import tcp_misc_pkg::*;
#(
    parameter int NUM_SRC   = NUM_SCHED_SRC,
    parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic            [NUM_SRC-1:0]       src_sched_cmd_val,
    input  sched_cmd_struct [NUM_SRC-1:0]       src_sched_cmd_data,
    output logic            [NUM_SRC-1:0]       src_sched_cmd_rdy,
    output logic                                arb_tx_sched_cmd_val,
    output sched_cmd_struct                     arb_tx_sched_cmd_data,
    input  logic                                tx_sched_arb_cmd_rdy,
    output logic            [SRC_IDX_W-1:0]     arb_last_src
);

    logic                 load_s;
    logic                 arb_en_s;
    logic [NUM_SRC-1:0]   gnt_s;
    logic [SRC_IDX_W-1:0] gnt_idx_s;
    logic                 gnt_vld_s;
    logic                 out_val_r;
    sched_cmd_struct      out_data_r;
    logic [SRC_IDX_W-1:0] last_src_r;

    // Register may take a new command when empty or being drained this cycle; rst_n gates
    // the grant so nothing is accepted while reset is held.
    always_comb begin
        load_s   = !out_val_r || tx_sched_arb_cmd_rdy;
        arb_en_s = load_s && rst_n;
    end

    rr_arb_core #(
        .NUM_SRC   (NUM_SRC),
        .SRC_IDX_W (SRC_IDX_W)
    ) u_rr_arb_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en_s),
        .req     (src_sched_cmd_val),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_vld (gnt_vld_s)
    );

    // Output stage: data and source index only change on a load with a winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_r  <= 1'b0;
            out_data_r <= '0;
            last_src_r <= '0;
        end else if (load_s) begin
            out_val_r <= gnt_vld_s;
            if (gnt_vld_s) begin
                out_data_r <= src_sched_cmd_data[gnt_idx_s];
                last_src_r <= gnt_idx_s;
            end else begin
                out_data_r <= out_data_r;
                last_src_r <= last_src_r;
            end
        end else begin
            out_val_r  <= out_val_r;
            out_data_r <= out_data_r;
            last_src_r <= last_src_r;
        end
    end

    // Drive ports from the stage registers and the combinational grant.
    always_comb begin
        src_sched_cmd_rdy     = gnt_s;
        arb_tx_sched_cmd_val  = out_val_r;
        arb_tx_sched_cmd_data = out_data_r;
        arb_last_src          = last_src_r;
    end

endmodule

// File: tb/tb_sched_cmd_arb.sv
// Self-checking bench for sched_cmd_arb: directed table, corner sequences and a randomized
// run against a transaction-level reference model.
module tb_sched_cmd_arb;
    import tcp_pkg::*;
    import tcp_misc_pkg::*;

    localparam int NS = NUM_SCHED_SRC;
    localparam int IW = $clog2(NS);
    localparam int CW = $bits(sched_cmd_struct);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NS-1:0]            src_val;
    sched_cmd_struct [NS-1:0] src_data;
    logic [NS-1:0]            src_rdy;
    logic                     out_val;
    sched_cmd_struct          out_data;
    logic                     tx_rdy;
    logic [IW-1:0]            last_src;

    always #5 clk = ~clk;

    sched_cmd_arb #(.NUM_SRC(NS), .SRC_IDX_W(IW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .src_sched_cmd_val     (src_val),
        .src_sched_cmd_data    (src_data),
        .src_sched_cmd_rdy     (src_rdy),
        .arb_tx_sched_cmd_val  (out_val),
        .arb_tx_sched_cmd_data (out_data),
        .tx_sched_arb_cmd_rdy  (tx_rdy),
        .arb_last_src          (last_src)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sched_cmd_struct mk_cmd(input int fid, input sched_op_e rt);
        sched_cmd_struct c;
        c.flowid = FLOWID_W'(fid);
        c.rt     = rt;
        c.probe  = SCHED_CLR;
        c.ka     = SCHED_NOP;
        return c;
    endfunction

    // Reference model: one-entry holding stage plus the index of the last winner.
    bit              m_full;
    sched_cmd_struct m_data;
    int              m_src;
    int              m_ptr;

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_src  = 0;
        m_ptr  = NS - 1;
    endtask

    function automatic int model_pick();
        if (m_full && !tx_rdy) return -1;
        for (int k = 1; k <= NS; k++) begin
            int c;
            c = (m_ptr + k) % NS;
            if (src_val[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_check(input int g);
        logic [NS-1:0] exp_rdy;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("rnd_rdy", 32'(src_rdy), 32'(exp_rdy));
        check("rnd_val", 32'(out_val), 32'(m_full));
        if (m_full) begin
            check("rnd_data", 32'(out_data), 32'(m_data));
            check("rnd_last", 32'(last_src), 32'(m_src));
        end
    endtask

    task automatic model_update(input int g);
        if (!m_full || tx_rdy) begin
            m_full = (g >= 0);
            if (g >= 0) begin
                m_data = src_data[g];
                m_src  = g;
                m_ptr  = g;
            end
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        src_val = '0;
        tx_rdy  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NS-1:0] val;
        logic          tx;
        logic [NS-1:0] exp_rdy;
        logic          exp_val;
        int            exp_last;
    } vec_t;

    vec_t tbl [13];

    initial begin
        bit   pend [NS];
        bit   pend2;
        int   waits;
        int   n2;
        int   g;
        logic [CW-1:0] rnd;

        tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b0, 0};
        tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 0};
        tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 1};
        tbl[3]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2};
        tbl[4]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2};
        tbl[5]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2};
        tbl[6]  = '{3'b000, 1'b1, 3'b000, 1'b1, 0};
        tbl[7]  = '{3'b000, 1'b1, 3'b000, 1'b0, 0};
        tbl[8]  = '{3'b100, 1'b0, 3'b100, 1'b0, 0};
        tbl[9]  = '{3'b010, 1'b0, 3'b000, 1'b1, 2};
        tbl[10] = '{3'b010, 1'b1, 3'b010, 1'b1, 2};
        tbl[11] = '{3'b000, 1'b1, 3'b000, 1'b1, 1};
        tbl[12] = '{3'b000, 1'b0, 3'b000, 1'b0, 1};

        // Reset held with every source requesting
        rst_n   = 1'b0;
        src_val = '1;
        tx_rdy  = 1'b1;
        for (int i = 0; i < NS; i++) src_data[i] = mk_cmd(10 + i, SCHED_SET);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy",  32'(src_rdy),  32'd0);
        check("rst_val",  32'(out_val),  32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(last_src), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table straight out of reset
        for (int i = 0; i < 13; i++) begin
            src_val = tbl[i].val;
            tx_rdy  = tbl[i].tx;
            @(negedge clk);
            check("tbl_rdy",  32'(src_rdy),  32'(tbl[i].exp_rdy));
            check("tbl_val",  32'(out_val),  32'(tbl[i].exp_val));
            check("tbl_last", 32'(last_src), 32'(tbl[i].exp_last));
            if (tbl[i].exp_val) check("tbl_data", 32'(out_data), 32'(src_data[tbl[i].exp_last]));
            @(posedge clk);
            #1;
        end

        // Backpressure: held command stays put, grant reappears with the drain
        do_reset();
        src_data[SCHED_SRC_TIMEOUT] = mk_cmd(5, SCHED_SET);
        src_data[SCHED_SRC_RX]      = mk_cmd(10, SCHED_SET);
        src_val = 3'b100;
        @(negedge clk);
        check("bp_grant", 32'(src_rdy), 32'b100);
        @(posedge clk);
        #1;
        src_val = 3'b001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rdy",  32'(src_rdy),  32'd0);
            check("bp_val",  32'(out_val),  32'd1);
            check("bp_data", 32'(out_data), 32'(mk_cmd(5, SCHED_SET)));
            check("bp_last", 32'(last_src), 32'd2);
            @(posedge clk);
            #1;
        end
        tx_rdy = 1'b1;
        @(negedge clk);
        check("bp_regrant", 32'(src_rdy),  32'b001);
        check("bp_data2",   32'(out_data), 32'(mk_cmd(5, SCHED_SET)));
        @(posedge clk);
        #1;
        src_val = '0;
        @(negedge clk);
        check("bp_next_data", 32'(out_data), 32'(mk_cmd(10, SCHED_SET)));
        check("bp_next_last", 32'(last_src), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_drained", 32'(out_val), 32'd0);

        // Sparse single request from one source
        do_reset();
        src_data[SCHED_SRC_APP] = mk_cmd(9, SCHED_CLR);
        src_val = 3'b010;
        tx_rdy  = 1'b1;
        @(negedge clk);
        check("sp_rdy", 32'(src_rdy), 32'b010);
        @(posedge clk);
        #1;
        src_val = '0;
        @(negedge clk);
        check("sp_val",  32'(out_val),  32'd1);
        check("sp_data", 32'(out_data), 32'(mk_cmd(9, SCHED_CLR)));
        check("sp_last", 32'(last_src), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sp_val_off", 32'(out_val), 32'd0);
        check("sp_rdy_off", 32'(src_rdy), 32'd0);

        // Asynchronous reset while a command is held under backpressure
        do_reset();
        src_data[SCHED_SRC_RX] = mk_cmd(7, SCHED_SET);
        src_val = 3'b001;
        @(posedge clk);
        #1;
        src_val = '1;
        @(negedge clk);
        check("ar_held", 32'(out_val), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_val",  32'(out_val),  32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_rdy",  32'(src_rdy),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_first_src0", 32'(src_rdy), 32'b001);
        check("ar_not_sent",   32'(out_val), 32'd0);
        @(posedge clk);
        #1;

        // Fairness under skew: source 0 always, source 2 every fourth cycle
        do_reset();
        tx_rdy = 1'b1;
        pend2  = 1'b0;
        waits  = 0;
        n2     = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc % 4 == 0) pend2 = 1'b1;
            src_val = {pend2, 1'b0, 1'b1};
            @(negedge clk);
            if (src_rdy[2]) begin
                check("fair_wait", 32'(waits <= 1), 32'd1);
                pend2 = 1'b0;
                waits = 0;
                n2++;
            end else if (src_rdy[0] && pend2) begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        check("fair_count", 32'(n2), 32'd10);

        // Randomized traffic against the reference model
        do_reset();
        for (int s = 0; s < NS; s++) pend[s] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int s = 0; s < NS; s++) begin
                if (!pend[s] && $urandom_range(0, 99) < 45) begin
                    pend[s]     = 1'b1;
                    rnd         = CW'($urandom);
                    src_data[s] = rnd;
                end
                src_val[s] = pend[s];
            end
            tx_rdy = ($urandom_range(0, 99) < 65);
            @(negedge clk);
            g = model_pick();
            model_check(g);
            @(posedge clk);
            #1;
            model_update(g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
